// File: rtl/alu_issue.sv
// alu_issue: execute-side issue stage. Decodes an RV32I instruction into ALU
// operands and a 4-bit function code, then queues the result in a 2-entry
// skid buffer whose head drives the ALU interface. in_ready is registered.
// Valid/ready: a transfer happens on a cycle where valid && ready are both high
// at the rising edge; the sender holds its payload stable until that happens.
// Optional feature: define RW_ALU_ISSUE_STALL_CNT_EN to add the stall_cnt output.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluin1,
  output logic [XLEN-1:0] aluin2,
  output logic [3:0]      funct_alu,
  output logic [4:0]      out_rd,
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a1;
    logic [XLEN-1:0] a2;
    logic [3:0]      funct;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic            legal;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));

  // Combinational decode of the incoming instruction into a buffer entry.
  always_comb begin
    legal       = 1'b1;
    dec.a1      = '0;
    dec.a2      = '0;
    dec.funct   = 4'b0000;
    dec.rd      = in_inst[11:7];
    dec.illegal = 1'b0;
    case (opcode)
      7'b0110011: begin // OP
        dec.a1    = in_rs1_data;
        dec.a2    = in_rs2_data;
        dec.funct = {f7[5], f3};
        if (f3 == 3'b010 || f3 == 3'b011) legal = 1'b0;
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
          legal = 1'b0;
      end
      7'b0010011: begin // OP-IMM
        dec.a1    = in_rs1_data;
        dec.a2    = imm_i;
        dec.funct = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        if (f3 == 3'b010 || f3 == 3'b011) legal = 1'b0;
        if (f3 == 3'b001 && f7 != 7'h00) legal = 1'b0;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
      end
      7'b0110111: dec.a2 = imm_u;                                      // LUI
      7'b0010111: begin dec.a1 = in_pc; dec.a2 = imm_u; end            // AUIPC
      7'b0000011: begin dec.a1 = in_rs1_data; dec.a2 = imm_i; end      // LOAD
      7'b0100011: begin dec.a1 = in_rs1_data; dec.a2 = imm_s; dec.rd = 5'd0; end // STORE
      7'b1101111, 7'b1100111: begin                                     // JAL/JALR link
        dec.a1 = in_pc;
        dec.a2 = XLEN'(4);
      end
      7'b1100011: begin                                                 // BRANCH compare
        dec.a1    = in_rs1_data;
        dec.a2    = in_rs2_data;
        dec.funct = 4'b1000;
        dec.rd    = 5'd0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a1      = '0;
      dec.a2      = '0;
      dec.funct   = 4'b0000;
      dec.rd      = 5'd0;
      dec.illegal = 1'b1;
    end
  end

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid && out_ready;

  // Skid buffer next state: head is the oldest entry, tail the second.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = dec;
          else               tail_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = dec;
          end else begin
            head_d = tail_q;
            tail_d = dec;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = (cnt_d <= 2'd1);
  end

  // Buffer state registers; reset clears contents so all outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign aluin1      = head_q.a1;
  assign aluin2      = head_q.a2;
  assign funct_alu   = head_q.funct;
  assign out_rd      = head_q.rd;
  assign out_illegal = head_q.illegal;

`ifdef RW_ALU_ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the head is blocked by the execute stage.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic against a
// queue-based reference model of the decode rules and the 2-entry buffer.
module tb_alu_issue;
  localparam int XLEN = 32;
  localparam int EW   = 2 * XLEN + 4 + 5 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] aluin1, aluin2;
  logic [3:0]      funct_alu;
  logic [4:0]      out_rd;
  logic            out_illegal;
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     exp_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic          exp_ready;

  // clock / reset
  always #5 clk = ~clk;

  alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .aluin1(aluin1), .aluin2(aluin2), .funct_alu(funct_alu), .out_rd(out_rd),
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_illegal(out_illegal)
  );

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode, written straight from the RV32I field rules.
  function automatic logic [EW-1:0] ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                               input logic [31:0] r1, input logic [31:0] r2);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a1, a2, imm_i, imm_s, imm_u;
    logic [3:0]  fn;
    logic [4:0]  rd;
    bit          ok;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_u = {i[31:12], 12'h000};
    ok = 1; a1 = 0; a2 = 0; fn = 0; rd = i[11:7];
    case (op)
      7'h33: begin
        a1 = r1; a2 = r2; fn = {f7[5], f3};
        if (f3 == 2 || f3 == 3) ok = 0;
        if (f7 != 0 && !(f7 == 7'h20 && (f3 == 0 || f3 == 5))) ok = 0;
      end
      7'h13: begin
        a1 = r1; a2 = imm_i; fn = {(f3 == 5) ? f7[5] : 1'b0, f3};
        if (f3 == 2 || f3 == 3) ok = 0;
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5 && f7 != 0 && f7 != 7'h20) ok = 0;
      end
      7'h37: a2 = imm_u;
      7'h17: begin a1 = pc; a2 = imm_u; end
      7'h03: begin a1 = r1; a2 = imm_i; end
      7'h23: begin a1 = r1; a2 = imm_s; rd = 0; end
      7'h6f, 7'h67: begin a1 = pc; a2 = 4; end
      7'h63: begin a1 = r1; a2 = r2; fn = 4'b1000; rd = 0; end
      default: ok = 0;
    endcase
    if (!ok) begin a1 = 0; a2 = 0; fn = 0; rd = 0; end
    return {a1, a2, fn, rd, !ok};
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", EW'(out_valid), EW'(exp_q.size() > 0));
    check_eq("in_ready", EW'(in_ready), EW'(exp_ready));
    if (exp_q.size() > 0)
      check_eq("head", {aluin1, aluin2, funct_alu, out_rd, out_illegal}, exp_q[0]);
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
    check_eq("stall_cnt", EW'(stall_cnt), EW'(exp_stall));
`endif
  endtask

  // driver: apply one cycle of inputs (called at a negedge), update model, check
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fl, input logic ordy);
    bit acc, pop;
    in_valid = v; in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    flush = fl; out_ready = ordy;
    acc = v && exp_ready && !fl;
    pop = (exp_q.size() > 0) && ordy;
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
    if (exp_q.size() > 0 && !ordy && exp_stall != 16'hFFFF) exp_stall++;
`endif
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_decode(inst, pc, r1, r2));
    end
    exp_ready = (exp_q.size() <= 1);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_ready = 1'b1;
`ifdef RW_ALU_ISSUE_STALL_CNT_EN
    exp_stall = 16'd0;
`endif
    check_eq("rst_outputs", {aluin1, aluin2, funct_alu, out_rd, out_illegal}, '0);
    check_eq("rst_valid", EW'(out_valid), '0);
    rst = 1'b0;
    check_eq("rst_ready", EW'(in_ready), EW'(1'b1));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops[10];
    int          k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 9);
    w[6:0] = (k == 9) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // stimulus
  initial begin
    rst = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    flush = 0; out_ready = 0; exp_ready = 1;
    @(negedge clk);
    do_reset();

    // ADD x3,x1,x2
    step(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 0, 1);
    check_eq("add_a1", EW'(aluin1), EW'(32'd5));
    check_eq("add_a2", EW'(aluin2), EW'(32'd7));
    check_eq("add_fn_rd", EW'({funct_alu, out_rd}), EW'({4'b0000, 5'd3}));
    // SRAI x5,x6,4
    step(1, 32'h40435293, 32'h0, 32'h80000000, 32'h0, 0, 1);
    check_eq("srai", EW'({funct_alu, aluin2, out_illegal}), EW'({4'b1101, 32'h00000404, 1'b0}));
    // AUIPC x1,0x12345
    step(1, 32'h12345097, 32'h100, 32'h0, 32'h0, 0, 1);
    check_eq("auipc", EW'({aluin1, aluin2, funct_alu}), EW'({32'h100, 32'h12345000, 4'b0000}));
    // SLT x1,x2,x3 is illegal here
    step(1, 32'h003120B3, 32'h40, 32'h11, 32'h22, 0, 1);
    check_eq("slt", {aluin1, aluin2, funct_alu, out_rd, out_illegal}, EW'(1));
    idle(1);

    // back-pressure: three instructions while execute is stalled
    step(1, 32'h002080B3, 0, 1, 1, 0, 0);
    step(1, 32'h00208133, 0, 2, 2, 0, 0);
    step(1, 32'h002081B3, 0, 3, 3, 0, 0);
    check_eq("bp_full_ready", EW'(in_ready), EW'(1'b0));
    check_eq("bp_head_rd", EW'(out_rd), EW'(5'd1));
    step(1, 32'h002081B3, 0, 3, 3, 0, 1);
    check_eq("bp_second_rd", EW'(out_rd), EW'(5'd2));
    step(1, 32'h002081B3, 0, 3, 3, 0, 1);
    check_eq("bp_third_rd", EW'(out_rd), EW'(5'd3));
    idle(1);

    // flush with 2 buffered entries and a concurrent valid input
    step(1, 32'h002080B3, 0, 1, 1, 0, 0);
    step(1, 32'h00208133, 0, 2, 2, 0, 0);
    step(1, 32'h002081B3, 0, 3, 3, 1, 0);
    check_eq("flush_valid", EW'(out_valid), EW'(1'b0));
    check_eq("flush_ready", EW'(in_ready), EW'(1'b1));
    idle(1);

    // randomized traffic with one mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
           $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
    end
    for (int n = 0; n < 4; n++) idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
